// File: rtl/smi_pkg.sv
// Shared definitions for the SMI frame arbiter and the steering stage it feeds:
// arbiter state encoding, end-of-frame helpers and the EOFC mask derivation.
package smi_pkg;

    localparam int EOFC_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_A = 2'd1,
        ARB_LOCK_B = 2'd2
    } arb_state_e;

    // A flit closes its frame when its (masked) end-of-frame control is non-zero.
    function automatic logic eofc_is_last(input logic [EOFC_W-1:0] eofc);
        return (eofc != 8'd0);
    endfunction

    function automatic int eofc_mask_for(input int flit_width);
        return 2 * flit_width - 1;
    endfunction

endpackage

// File: rtl/smi_input_slice.sv
// Registered SMI input stage: captures one flit, masks its EOFC and back-pressures
// the producer while the captured flit cannot move on.
module smi_input_slice
    import smi_pkg::*;
#(
    parameter int FlitWidth = 16,
    parameter int EofcMask  = eofc_mask_for(FlitWidth)
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   in_ready_i,
    input  logic [EOFC_W-1:0]      in_eofc_i,
    input  logic [FlitWidth*8-1:0] in_data_i,
    input  logic                   halt_i,
    output logic                   stop_o,
    output logic                   ready_o,
    output logic [EOFC_W-1:0]      eofc_o,
    output logic [FlitWidth*8-1:0] data_o
);

    localparam logic [EOFC_W-1:0] EOFC_MASK_8 = EofcMask[7:0];

    logic                   ready_q;
    logic [EOFC_W-1:0]      eofc_q;
    logic [FlitWidth*8-1:0] data_q;
    logic                   stop_s;

    assign stop_s  = ready_q & halt_i;
    assign stop_o  = stop_s;
    assign ready_o = ready_q;
    assign eofc_o  = eofc_q;
    assign data_o  = data_q;

    // Flit-valid register; the only reset state of the slice.
    always_ff @(posedge clk) begin
        if (srst) begin
            ready_q <= 1'b0;
        end else if (!stop_s) begin
            ready_q <= in_ready_i;
        end
    end

    // Payload register; contents are meaningless while ready_q is low.
    always_ff @(posedge clk) begin
        if (!stop_s) begin
            eofc_q <= in_eofc_i & EOFC_MASK_8;
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/smi_frame_arbiter_x2.sv
// Two-input SMI merge with frame-level round-robin arbitration: a granted frame
// is passed through whole before the other input may be served.
module smi_frame_arbiter_x2
    import smi_pkg::*;
#(
    parameter int FlitWidth = 16,
    parameter int EofcMask  = eofc_mask_for(FlitWidth)
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiInAReady,
    input  logic [7:0]             smiInAEofc,
    input  logic [FlitWidth*8-1:0] smiInAData,
    output logic                   smiInAStop,
    input  logic                   smiInBReady,
    input  logic [7:0]             smiInBEofc,
    input  logic [FlitWidth*8-1:0] smiInBData,
    output logic                   smiInBStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
);

    localparam int DW = FlitWidth * 8;

    logic            a_ready_s, b_ready_s;
    logic [7:0]      a_eofc_s, b_eofc_s;
    logic [DW-1:0]   a_data_s, b_data_s;
    logic            halt_a_s, halt_b_s;

    arb_state_e      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_valid_s, grant_sel_s;
    logic            sel_ready_s, xfer_s, out_hold_s;
    logic [7:0]      sel_eofc_s;
    logic [DW-1:0]   sel_data_s;

    logic            out_ready_q;
    logic [7:0]      out_eofc_q;
    logic [DW-1:0]   out_data_q;

    assign out_hold_s  = out_ready_q & smiOutStop;
    assign halt_a_s    = ~(grant_valid_s & ~grant_sel_s) | out_hold_s;
    assign halt_b_s    = ~(grant_valid_s &  grant_sel_s) | out_hold_s;
    assign smiOutReady = out_ready_q;
    assign smiOutEofc  = out_eofc_q;
    assign smiOutData  = out_data_q;

    smi_input_slice #(.FlitWidth(FlitWidth), .EofcMask(EofcMask)) u_slice_a (
        .clk        (clk),
        .srst       (srst),
        .in_ready_i (smiInAReady),
        .in_eofc_i  (smiInAEofc),
        .in_data_i  (smiInAData),
        .halt_i     (halt_a_s),
        .stop_o     (smiInAStop),
        .ready_o    (a_ready_s),
        .eofc_o     (a_eofc_s),
        .data_o     (a_data_s)
    );

    smi_input_slice #(.FlitWidth(FlitWidth), .EofcMask(EofcMask)) u_slice_b (
        .clk        (clk),
        .srst       (srst),
        .in_ready_i (smiInBReady),
        .in_eofc_i  (smiInBEofc),
        .in_data_i  (smiInBData),
        .halt_i     (halt_b_s),
        .stop_o     (smiInBStop),
        .ready_o    (b_ready_s),
        .eofc_o     (b_eofc_s),
        .data_o     (b_data_s)
    );

    // Grant selection and frame-lock tracking; grant is combinational so a
    // newly arbitrated flit moves in the same cycle.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (a_ready_s && b_ready_s) begin
                    grant_valid_s = 1'b1;
                    grant_sel_s   = ~last_grant_q;
                end else if (a_ready_s) begin
                    grant_valid_s = 1'b1;
                    grant_sel_s   = 1'b0;
                end else if (b_ready_s) begin
                    grant_valid_s = 1'b1;
                    grant_sel_s   = 1'b1;
                end else begin
                    grant_valid_s = 1'b0;
                end
            end
            ARB_LOCK_A: begin
                grant_valid_s = 1'b1;
                grant_sel_s   = 1'b0;
            end
            ARB_LOCK_B: begin
                grant_valid_s = 1'b1;
                grant_sel_s   = 1'b1;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        sel_ready_s = grant_sel_s ? b_ready_s : a_ready_s;
        sel_eofc_s  = grant_sel_s ? b_eofc_s  : a_eofc_s;
        sel_data_s  = grant_sel_s ? b_data_s  : a_data_s;
        xfer_s      = grant_valid_s & sel_ready_s & ~out_hold_s;

        if (xfer_s) begin
            if (eofc_is_last(sel_eofc_s)) begin
                state_d      = ARB_IDLE;
                last_grant_d = grant_sel_s;
            end else begin
                state_d = grant_sel_s ? ARB_LOCK_B : ARB_LOCK_A;
            end
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Arbiter state and output-valid registers; lastGrant resets to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            out_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (!out_hold_s) begin
                out_ready_q <= grant_valid_s & sel_ready_s;
            end
        end
    end

    // Output payload register, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!out_hold_s) begin
            out_eofc_q <= sel_eofc_s;
            out_data_q <= sel_data_s;
        end
    end

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// Randomized bench for smi_frame_arbiter_x2 against a frame-level reference model.
module tb_smi_frame_arbiter_x2;

    localparam int FW = 16;
    localparam int DW = FW * 8;
    localparam logic [7:0] MASK = 8'(2 * FW - 1);

    typedef struct packed {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          smiInAReady, smiInBReady, smiInAStop, smiInBStop;
    logic [7:0]    smiInAEofc, smiInBEofc, smiOutEofc;
    logic [DW-1:0] smiInAData, smiInBData, smiOutData;
    logic          smiOutReady, smiOutStop;

    smi_frame_arbiter_x2 #(.FlitWidth(FW)) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInAReady (smiInAReady),
        .smiInAEofc  (smiInAEofc),
        .smiInAData  (smiInAData),
        .smiInAStop  (smiInAStop),
        .smiInBReady (smiInBReady),
        .smiInBEofc  (smiInBEofc),
        .smiInBData  (smiInBData),
        .smiInBStop  (smiInBStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-input queues of accepted flits awaiting output.
    flit_t qa[$];
    flit_t qb[$];
    bit    in_frame, cur_src, last_g;
    flit_t shown;

    // Pre-edge snapshot
    logic          s_srst, s_out_ready, s_out_stop;
    logic          s_ready[2], s_stop[2];
    logic [7:0]    s_eofc[2];
    logic [DW-1:0] s_data[2];
    bit            s_gv, s_src;

    // Producer state
    bit            drv_valid[2];
    int            drv_rem[2];
    logic [7:0]    drv_eofc[2];
    logic [DW-1:0] drv_data[2];

    function automatic bit has_flit(input bit src);
        return src ? (qb.size() != 0) : (qa.size() != 0);
    endfunction

    // Which input owns the output next: locked frame owner, else round robin.
    function automatic void pick(output bit gv, output bit src);
        bit na, nb;
        na = has_flit(1'b0);
        nb = has_flit(1'b1);
        if (in_frame) begin
            gv = 1'b1; src = cur_src;
        end else if (na && nb) begin
            gv = 1'b1; src = ~last_g;
        end else begin
            gv = na | nb; src = nb & ~na;
        end
    endfunction

    function automatic logic [7:0] last_eofc();
        if ($urandom_range(0, 7) == 0) return 8'hFF;
        return 8'($urandom_range(1, 31));
    endfunction

    task automatic drive_input(input int x, input int pct);
        bit acc;
        acc = s_ready[x] && !s_stop[x];
        if (s_srst) begin
            drv_valid[x] = 1'b0;
            drv_rem[x]   = 0;
        end else if (!(drv_valid[x] && !acc)) begin
            if (acc) drv_rem[x]--;
            drv_valid[x] = 1'b0;
            if ($urandom_range(0, 99) < pct) begin
                if (drv_rem[x] == 0) drv_rem[x] = $urandom_range(1, 4);
                drv_valid[x] = 1'b1;
                drv_eofc[x]  = (drv_rem[x] == 1) ? last_eofc() : 8'd0;
                drv_data[x]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    endtask

    initial begin
        flit_t f;
        bit    exp_fresh, out_hold;
        int    pct;
        srst = 1'b1; smiOutStop = 1'b0;
        smiInAReady = 1'b0; smiInAEofc = 8'd0; smiInAData = '0;
        smiInBReady = 1'b0; smiInBEofc = 8'd0; smiInBData = '0;
        s_srst = 1'b1; s_out_ready = 1'b0; s_out_stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_ready[i] = 1'b0; s_stop[i] = 1'b0; drv_valid[i] = 1'b0; drv_rem[i] = 0;
        end
        in_frame = 1'b0; cur_src = 1'b0; last_g = 1'b1; shown = '0;

        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (s_srst) begin
                check_eq("rst_out_ready", DW'(smiOutReady), DW'(1'b0));
                check_eq("rst_stop_a", DW'(smiInAStop), DW'(1'b0));
                check_eq("rst_stop_b", DW'(smiInBStop), DW'(1'b0));
                qa.delete(); qb.delete();
                in_frame = 1'b0; last_g = 1'b1;
            end else begin
                if (s_out_ready && s_out_stop) begin
                    check_eq("hold_ready", DW'(smiOutReady), DW'(1'b1));
                    check_eq("hold_eofc", DW'(smiOutEofc), DW'(shown.eofc));
                    check_eq("hold_data", smiOutData, shown.data);
                end else begin
                    exp_fresh = s_gv && has_flit(s_src);
                    check_eq("out_ready", DW'(smiOutReady), DW'(exp_fresh));
                    if (smiOutReady && exp_fresh) begin
                        f = s_src ? qb.pop_front() : qa.pop_front();
                        shown = f;
                        check_eq("out_eofc", DW'(smiOutEofc), DW'(f.eofc));
                        check_eq("out_data", smiOutData, f.data);
                        if (f.eofc != 8'd0) begin
                            in_frame = 1'b0; last_g = s_src;
                        end else begin
                            in_frame = 1'b1; cur_src = s_src;
                        end
                    end
                end
                if (s_ready[0] && !s_stop[0]) qa.push_back('{eofc: s_eofc[0] & MASK, data: s_data[0]});
                if (s_ready[1] && !s_stop[1]) qb.push_back('{eofc: s_eofc[1] & MASK, data: s_data[1]});
            end

            // Phases: tie-heavy start, random traffic with a mid-run reset, stall bursts, drain.
            srst = (cyc < 2) || (cyc == 250);
            pct  = (cyc < 60) ? 100 : ((cyc >= 600) ? 0 : 60);
            drive_input(0, pct);
            drive_input(1, pct);
            smiInAReady = drv_valid[0]; smiInAEofc = drv_eofc[0]; smiInAData = drv_data[0];
            smiInBReady = drv_valid[1]; smiInBEofc = drv_eofc[1]; smiInBData = drv_data[1];
            if (cyc < 60 || cyc >= 600)  smiOutStop = 1'b0;
            else if (cyc >= 400)         smiOutStop = ((cyc % 12) < 5);
            else                         smiOutStop = ($urandom_range(0, 99) < 30);

            #1;
            s_srst      = srst;
            s_out_ready = smiOutReady;
            s_out_stop  = smiOutStop;
            s_ready[0] = smiInAReady; s_stop[0] = smiInAStop; s_eofc[0] = smiInAEofc; s_data[0] = smiInAData;
            s_ready[1] = smiInBReady; s_stop[1] = smiInBStop; s_eofc[1] = smiInBEofc; s_data[1] = smiInBData;
            pick(s_gv, s_src);
            out_hold = smiOutReady && smiOutStop;
            check_eq("stop_a", DW'(smiInAStop),
                     DW'(has_flit(1'b0) && (out_hold || !(s_gv && s_src == 1'b0))));
            check_eq("stop_b", DW'(smiInBStop),
                     DW'(has_flit(1'b1) && (out_hold || !(s_gv && s_src == 1'b1))));
        end

        check_eq("drain_a", DW'(qa.size()), DW'(0));
        check_eq("drain_b", DW'(qb.size()), DW'(0));
        check_eq("drain_out_ready", DW'(smiOutReady), DW'(1'b0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/smi_frame_arbiter_x2.md
Name: smi_frame_arbiter_x2

Overview:
- Merges two SMI input streams into one SMI output with frame-level round-robin arbitration.
- Once a frame is granted, all of its flits pass through uninterrupted; flits from the two inputs are never interleaved within a frame.
- Sits directly upstream of the frame steering stage and drives its combined SMI input, so several producers can share one steered channel.

Parameters:
- FlitWidth, 16, flit width in bytes; data bus is FlitWidth*8 bits wide; must be at least 4.
- EofcMask, 2*FlitWidth-1, mask applied to end-of-frame control bits on entry.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- srst  in  1  reset; synchronous, active-high.
- smiInAReady  in  1  input A flit valid.
- smiInAEofc  in  8  input A end-of-frame control; 0 means not the last flit, otherwise the last flit and its byte count.
- smiInAData  in  FlitWidth*8  input A flit data.
- smiInAStop  out  1  input A backpressure.
- smiInBReady, smiInBEofc, smiInBData, smiInBStop: same as the A ports, for input B.
- smiOutReady  out  1  output flit valid.
- smiOutEofc  out  8  output end-of-frame control.
- smiOutData  out  FlitWidth*8  output flit data.
- smiOutStop  in  1  output backpressure.

Behaviour:
- Handshake on every SMI link: a flit transfers on a clock edge where Ready=1 and Stop=0. While Stop=1 the producer holds Ready, Eofc and Data stable.
- Input stage, one per input:
  - Registers inReady_q, eofc_q (masked with EofcMask[7:0]) and data_q.
  - Loads whenever ~(inReady_q & haltX).
  - smiInXStop = inReady_q & haltX, where haltX = ~(grant selects X) | outHold.
- Output stage:
  - Registers smiOutReady, smiOutEofc and smiOutData.
  - outHold = smiOutReady & smiOutStop. The register loads whenever ~outHold.
  - It loads the granted input's registered flit; smiOutReady takes the granted inReady_q, or 0 if there is no grant.
- Latency: 2 cycles from input acceptance to smiOutReady, with no stalls. Sustained throughput is 1 flit/cycle.
- Arbiter FSM states, with register lastGrant (0=A, 1=B):
  - IDLE: at a frame boundary. If only one inReady_q is set, grant that input. If both are set, grant the input other than lastGrant. The grant is combinational, so the first flit moves in the same cycle.
  - LOCK_A / LOCK_B: grant is held on A / B regardless of the other input.
- FSM transitions, evaluated on each transfer into the output register:
  - eofc_q==0 (not last): IDLE -> LOCK_X; LOCK_X stays in LOCK_X.
  - eofc_q!=0 (last): go to (or stay in) IDLE and set lastGrant=X. A single-flit frame therefore stays in IDLE.
- In LOCK_X with inReady_q of X low, no flit is emitted (bubble). The other input stays stopped once its inReady_q is set.
- Stall behaviour:
  - While outHold is set, no FSM transition and no lastGrant update occur.
  - Input registers of both inputs hold whenever that input's Stop is asserted.
  - No flit is dropped or duplicated.
- Reset values: all inReady_q=0, smiOutReady=0, FSM=IDLE, lastGrant=1 (so A wins the first tie), smiInAStop=0, smiInBStop=0.
  - smiOutEofc and smiOutData are not reset; they are don't-care while smiOutReady=0.
- Reset asserted mid-frame: the frame in progress is abandoned, and the next cycle behaves as power-up. Upstream must also be reset.
- Simultaneous events:
  - The last flit of frame A transferring while B is waiting: the next IDLE arbitration sees lastGrant=A and grants B immediately, with no idle cycle.
  - An input whose inReady_q is set while the other input is locked stalls until that frame ends.

Decomposition:
- Shared package (smi_pkg):
  - FSM state encodings (IDLE=2'd0, LOCK_A=2'd1, LOCK_B=2'd2).
  - A helper function testing "eofc is last" (eofc != 0).
  - The EofcMask derivation, shared with the steering stage.
- One sub-module, smi_input_slice: the registered, stop-generating input stage, instantiated twice (A and B), with parameters FlitWidth and EofcMask.

Test Plan:
1. Single flit on A only: A sends Eofc=8'd4, Data=0x1234 with B idle -> smiOutReady=1 two cycles later with the same Eofc and Data; FSM stays IDLE; lastGrant=A.
2. Tie after reset: A and B each present a 3-flit frame (Eofc 0,0,16) in the same cycle -> output carries A's 3 flits, then B's 3, back to back with no bubble; smiInBStop=1 throughout A's frame.
3. No interleave: while A is in LOCK_A (1st of 4 flits sent), B presents a 1-flit frame -> B's flit appears only after A's flit with Eofc!=0; output order is A0, A1, A2, A3, B0.
4. Backpressure: smiOutStop held at 1 for 5 cycles mid-frame on A -> output register frozen, smiInAStop=1 within one cycle, no flit lost or duplicated; all 4 flits appear in order after release.
5. Eofc masking: FlitWidth=16, A sends Eofc=8'hFF -> smiOutEofc=8'h1F.
6. Mid-frame reset: srst pulsed for 1 cycle during A's 2nd flit -> next cycle smiOutReady=0, FSM=IDLE, both Stops=0; a new B frame is then accepted first.
